// File: rtl/spi_resp_pkg.sv
// spi_resp_pkg: opcodes, FSM states and JEDEC byte select shared by the SPI flash responder
package spi_resp_pkg;
  localparam logic [7:0] OpRead     = 8'h03;
  localparam logic [7:0] OpFastRead = 8'h0B;
  localparam logic [7:0] OpRdStatus = 8'h05;
  localparam logic [7:0] OpJedec    = 8'h9F;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, IGNORE} spi_resp_state_e;
  function automatic logic [7:0] jedec_byte(input logic [23:0] id, input logic [1:0] idx);
    return idx == 2'd0 ? id[23:16] : idx == 2'd1 ? id[15:8] : id[7:0];
  endfunction
endpackage

// File: rtl/spi_resp_mem.sv
// spi_resp_mem: byte RAM with preload write port and registered read-before-write read port
module spi_resp_mem
  import spi_resp_pkg::*;
#(
  parameter int MemBytes  = 4096,
  parameter int AddrWidth = $clog2(MemBytes)
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [7:0]           wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [7:0]           rdata_o
);
  logic [7:0] mem [MemBytes];
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_o <= mem[raddr_i];
  end
endmodule

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash target serving READ, READ STATUS and JEDEC ID from a preloaded array
// Define SPI_RESP_FAST_READ_EN to also serve FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_responder
  import spi_resp_pkg::*;
#(
  parameter int          MemBytes   = 4096,
  parameter int          AddrWidth  = $clog2(MemBytes),
  parameter logic [23:0] JedecId    = 24'hEF4018,
  parameter int          SyncStages = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 spi_sck_i,
  input  logic                 spi_csb_i,
  input  logic                 spi_sd_i,
  output logic                 spi_sd_o,
  output logic                 spi_sd_en_o,
  input  logic                 mem_we_i,
  input  logic [AddrWidth-1:0] mem_addr_i,
  input  logic [7:0]           mem_wdata_i,
  output logic                 busy_o,
  output logic                 cmd_err_o
);
`ifdef SPI_RESP_FAST_READ_EN
  localparam bit FastEn = 1'b1;
`else
  localparam bit FastEn = 1'b0;
`endif
  spi_resp_state_e state, state_n;
  logic [SyncStages-1:0] sck_s, csb_s, sd_s;
  logic sck_q, csb_q, csb, sck_rise, sck_fall, byte_done, word_end, resp, op_ok;
  logic fast, rd_req, rd_vld, sd_o, cmd_err;
  logic [2:0] bit_cnt;
  logic [6:0] rx;
  logic [7:0] rx_byte, tx, rdata;
  logic [AddrWidth-1:0] addr;
  logic [1:0] abyte, id_idx;
  // Sync chains reset to 0 so a csb held low through reset never looks like a fresh select
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sck_s <= '0;
      csb_s <= '0;
      sd_s  <= '0;
    end else begin
      sck_s <= {sck_s[SyncStages-2:0], spi_sck_i};
      csb_s <= {csb_s[SyncStages-2:0], spi_csb_i};
      sd_s  <= {sd_s[SyncStages-2:0], spi_sd_i};
    end
  assign csb       = csb_s[SyncStages-1];
  assign sck_rise  = sck_s[SyncStages-1] & ~sck_q;
  assign sck_fall  = ~sck_s[SyncStages-1] & sck_q;
  assign rx_byte   = {rx, sd_s[SyncStages-1]};
  assign byte_done = sck_rise && bit_cnt == 3'd7;
  assign word_end  = sck_fall && bit_cnt == 3'd7;
  assign resp      = state inside {DATA, ID, STAT};
  assign op_ok     = rx_byte inside {OpRead, OpRdStatus, OpJedec} || (FastEn && rx_byte == OpFastRead);
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = csb_q && !csb ? CMD : IDLE;
      CMD:     if (byte_done) state_n = !op_ok ? IGNORE : rx_byte == OpJedec ? ID : rx_byte == OpRdStatus ? STAT : ADDR;
      ADDR:    if (byte_done && abyte == 2'd2) state_n = fast ? DUMMY : DATA;
      DUMMY:   if (byte_done) state_n = DATA;
      default: state_n = state;
    endcase
    if (state != IDLE && csb) state_n = IDLE;
  end
  always_ff @(posedge clk_i)
    if (rst_i) begin
      sck_q   <= 1'b0;
      csb_q   <= 1'b0;
      bit_cnt <= '0;
      rx      <= '0;
      tx      <= '0;
      sd_o    <= 1'b0;
      addr    <= '0;
      abyte   <= '0;
      id_idx  <= '0;
      fast    <= 1'b0;
      rd_req  <= 1'b0;
      rd_vld  <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      sck_q   <= sck_s[SyncStages-1];
      csb_q   <= csb;
      cmd_err <= 1'b0;
      rd_req  <= 1'b0;
      rd_vld  <= rd_req;
      if (state == IDLE || csb) begin
        bit_cnt <= '0;
        rx      <= '0;
        sd_o    <= 1'b0;
      end else begin
        if (sck_rise) begin
          rx      <= rx_byte[6:0];
          bit_cnt <= bit_cnt + 3'd1;
        end
        if (sck_fall && resp) begin
          sd_o <= tx[7];
          tx   <= {tx[6:0], 1'b0};
        end
        if (byte_done && state == CMD) begin
          abyte   <= '0;
          fast    <= rx_byte == OpFastRead;
          tx      <= rx_byte == OpJedec ? jedec_byte(JedecId, 2'd0) : 8'h00;
          id_idx  <= 2'd1;
          cmd_err <= !op_ok;
        end
        // Only the low address bits are kept, so upper bits shift out and reads wrap modulo MemBytes
        if (byte_done && state == ADDR) begin
          addr   <= AddrWidth'({addr, rx_byte});
          abyte  <= abyte + 2'd1;
          rd_req <= abyte == 2'd2;
        end
        if (word_end && state == DATA) begin
          addr   <= addr + 1'b1;
          rd_req <= 1'b1;
        end
        if (word_end && state == ID) begin
          tx     <= jedec_byte(JedecId, id_idx);
          id_idx <= id_idx == 2'd2 ? 2'd0 : id_idx + 2'd1;
        end
        if (rd_vld) tx <= rdata;
      end
    end
  spi_resp_mem #(.MemBytes(MemBytes), .AddrWidth(AddrWidth)) u_mem (
    .clk_i   (clk_i),
    .we_i    (mem_we_i),
    .waddr_i (mem_addr_i),
    .wdata_i (mem_wdata_i),
    .raddr_i (addr),
    .rdata_o (rdata)
  );
  assign spi_sd_o    = sd_o;
  assign spi_sd_en_o = resp && !csb;
  assign busy_o      = state != IDLE;
  assign cmd_err_o   = cmd_err;
endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
- Simulation and FPGA-side SPI flash target. It answers the Cheshire SPI host (spih_sck/csb/sd) during boot bring-up on boards without a real flash.
- Single-lane SPI mode 0 (CPOL=0, CPHA=0). All SPI pins are oversampled in the clk_i domain.
- Serves READ, optional FAST READ, READ STATUS and JEDEC ID out of a byte array. The host side preloads the array through a write port.

Parameters:
- MemBytes, 4096, byte array depth; power of two.
- AddrWidth, $clog2(MemBytes), internal array index width.
- JedecId, 24'hEF4018, bytes returned by 0x9F, MSB byte first.
- SyncStages, 2, flops per SPI input synchronizer; at least 2.

Ports:
- clk_i  in  1  system clock; must be at least 8x the SCK frequency.
- rst_i  in  1  synchronous, active-high reset.
- spi_sck_i  in  1  SPI clock from host.
- spi_csb_i  in  1  chip select, active low.
- spi_sd_i  in  1  MOSI.
- spi_sd_o  out  1  MISO.
- spi_sd_en_o  out  1  MISO output enable; drives the tristate.
- mem_we_i  in  1  preload write strobe.
- mem_addr_i  in  AddrWidth  preload byte address.
- mem_wdata_i  in  8  preload byte.
- busy_o  out  1  high while CS is asserted (synced).
- cmd_err_o  out  1  one-cycle pulse on an unsupported opcode.

Behaviour:
- Reset values: spi_sd_o=0, spi_sd_en_o=0, busy_o=0, cmd_err_o=0, FSM=IDLE, bit counter=0, shift registers=0. The memory array is not reset.
- Synchronizers:
  - sck, csb and sd each pass through SyncStages flops.
  - sck_rise/sck_fall are derived from the last two synced sck samples.
  - All protocol actions are evaluated only on these edges.
- Sampling and shifting:
  - On sck_rise: shift the synced sd into the 8-bit rx register and increment the 3-bit bit counter.
  - On sck_fall: shift tx register MSB to spi_sd_o, but only in response states.
- Byte completion: when the bit counter wraps 7->0 on sck_rise, a byte is complete and drives the FSM.
- FSM transitions:
  - IDLE: synced csb low -> CMD, busy_o=1.
  - CMD, byte done:
    - 0x03 -> ADDR.
    - 0x9F -> ID; tx loaded with JedecId[23:16].
    - 0x05 -> STAT; tx=8'h00.
    - 0x0B -> ADDR (only if the feature is enabled).
    - Anything else -> IGNORE, cmd_err_o pulses for 1 cycle.
  - ADDR:
    - Collects 3 bytes MSB first into a 24-bit register.
    - After the third byte, load tx with mem[addr[AddrWidth-1:0]].
    - Next state is DATA, or DUMMY for FAST READ.
  - DATA:
    - After each 8th sck_fall, increment addr and reload tx with the next byte.
    - Address wraps modulo MemBytes; upper address bits are ignored.
  - ID: streams the 3 JedecId bytes in order, then repeats from the first byte.
  - STAT: repeats 0x00.
  - IGNORE: spi_sd_en_o=0; waits for CS deassertion.
- Output timing:
  - The first response bit is driven on the sck_fall that follows the last command/address bit's sck_rise.
  - Data is valid before the next rising edge, as mode 0 requires.
- Output enable: spi_sd_en_o=1 only in DATA/ID/STAT while csb is low; 0 otherwise.
- CS deassertion: synced csb high in any state -> IDLE next cycle. Bit counter is cleared, spi_sd_en_o=0, busy_o=0. Partial bytes are discarded.
- Simultaneous events:
  - CS rise in the same cycle as a byte completion: CS wins.
  - A preload write in the same cycle as a tx load: the tx byte reads the old array content (read-before-write).
- Memory read latency: 1-cycle registered read. The oversampling ratio guarantees the byte is ready before the next sck_fall.
- Reset mid-transaction: rst_i forces IDLE immediately. The responder stays in IDLE until it sees a fresh csb high->low.

Optional Feature:
- Macro: SPI_RESP_FAST_READ_EN.
- Defined: opcode 0x0B goes CMD -> ADDR -> DUMMY. DUMMY discards 8 clocks with spi_sd_en_o=0, then enters DATA.
- Undefined: 0x0B is treated as unsupported -> IGNORE with a cmd_err_o pulse.

Decomposition:
- Shared package spi_resp_pkg:
  - Opcode localparams: OpRead=8'h03, OpFastRead=8'h0B, OpRdStatus=8'h05, OpJedec=8'h9F.
  - State enum spi_resp_state_e: IDLE, CMD, ADDR, DUMMY, DATA, ID, STAT, IGNORE.
- Sub-module spi_resp_mem: a simple dual-port byte RAM with a preload write port and a registered read port, which infers BRAM on FPGA.

Test Plan:
- Preload mem[0x010..0x013]=DE AD BE EF; send 03 00 00 10 then 32 clocks -> MISO yields DE AD BE EF, cmd_err_o stays 0.
- Send 9F then 48 clocks -> EF 40 18 EF 40 18.
- READ at address 0x000FFF with MemBytes=4096, mem[0xFFF]=0x5A, mem[0]=0xA5 -> 5A then A5 (wrap).
- Send opcode 0x42 -> cmd_err_o pulses exactly 1 cycle, spi_sd_en_o stays 0 until CS rises; the next 03 transaction succeeds.
- Raise CS after 13 bits of the address phase, then send a fresh 05 -> returns 00; no stale address is used.
- With SPI_RESP_FAST_READ_EN: 0B 00 00 10 plus 8 dummy clocks -> DE AD; without it: cmd_err_o pulse and MISO disabled.
